// File: rtl/expr_gen_if.sv
// Character stream handshake between the expression generator and its consumer.
interface expr_gen_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_last;

    modport master (output out_valid, output out_char, output out_last, input out_ready);
    modport slave  (input out_valid, input out_char, input out_last, output out_ready);
endinterface

// File: rtl/expr_gen.sv
// Pseudo-random arithmetic-expression generator: emits digit/operator ASCII bytes
// ("d+d*d...") one per handshake, driven by an 8-bit Fibonacci LFSR.
module expr_gen #(
    parameter int MAX_TERMS = 15
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [3:0]  terms,
    input  logic [7:0]  seed,
    output logic        busy,
    expr_gen_if.master  out_if
);

    typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;

    logic        xfer;
    logic        accept;
    logic [7:0]  seed_eff;
    logic [7:0]  lfsr_nxt;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Nibbles 10..15 fold back onto 0..5 so every LFSR value maps to a digit.
    function automatic logic [7:0] digit_char(input logic [7:0] l);
        logic [3:0] d;
        d = (l[3:0] < 4'd10) ? l[3:0] : l[3:0] - 4'd10;
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic [7:0] l);
        return l[0] ? 8'h2A : 8'h2B;
    endfunction

    assign xfer     = valid_q && out_if.out_ready;
    assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign accept   = (state_q == IDLE) && start && (terms != 4'd0)
                      && (int'(terms) <= MAX_TERMS);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lfsr_d  = seed_eff;
                    cnt_d   = terms;
                    char_d  = digit_char(seed_eff);
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_q - 4'd1;
                    // Final digit: return to IDLE and leave out_char at its last value.
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = OP;
                        char_d  = op_char(lfsr_nxt);
                    end
                end
            end
            OP: begin
                if (xfer) begin
                    lfsr_d  = lfsr_nxt;
                    state_d = DIGIT;
                    char_d  = digit_char(lfsr_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        last_d  = (state_d == DIGIT) && (cnt_d == 4'd1);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            lfsr_q  <= 8'h01;
            cnt_q   <= 4'd0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_char  = char_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_expr_gen.sv
// Scoreboard bench for expr_gen: a reference model queues expected bytes at start,
// a negedge monitor pops and compares them and checks handshake hold and expression format.
module tb_expr_gen;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] terms = 4'd0;
    logic [7:0] seed = 8'h00;
    logic       busy;

    expr_gen_if ifc();

    expr_gen #(.MAX_TERMS(15)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .terms  (terms),
        .seed   (seed),
        .busy   (busy),
        .out_if (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] m_digit(input logic [7:0] l);
        int n;
        n = int'(l[3:0]);
        if (n >= 10) n = n - 10;
        return 8'(8'h30 + n);
    endfunction

    task automatic push_stream(input logic [7:0] s, input int n);
        logic [7:0] l;
        l = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < 2 * n - 1; i++) begin
            if (i % 2 == 0) exp_q.push_back({(i == 2 * n - 2), m_digit(l)});
            else            exp_q.push_back({1'b0, (l[0] ? 8'h2A : 8'h2B)});
            l = m_step(l);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || ifc.out_valid) && n < bound) begin
            cyc();
            n++;
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    // Monitor: scoreboard compare, backpressure hold, and expression grammar.
    logic       stall_p = 1'b0;
    logic [7:0] hold_char = 8'h00;
    logic       hold_last = 1'b0;
    logic       want_digit = 1'b1;
    logic       expr_ok = 1'b1;

    always @(negedge clk) begin
        if (!clr_n) begin
            stall_p    = 1'b0;
            want_digit = 1'b1;
            expr_ok    = 1'b1;
        end else begin
            if (stall_p) begin
                check_eq("hold_valid", 32'(ifc.out_valid), 32'd1);
                check_eq("hold_char", 32'(ifc.out_char), 32'(hold_char));
                check_eq("hold_last", 32'(ifc.out_last), 32'(hold_last));
            end
            if (ifc.out_valid && ifc.out_ready) begin
                logic [8:0] e;
                logic       is_dig;
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_char", 32'(ifc.out_char), 32'(e[7:0]));
                    check_eq("sb_last", 32'(ifc.out_last), 32'(e[8]));
                end
                is_dig = (ifc.out_char >= 8'h30) && (ifc.out_char <= 8'h39);
                if (want_digit) expr_ok = expr_ok && is_dig;
                else            expr_ok = expr_ok && (ifc.out_char == 8'h2A || ifc.out_char == 8'h2B);
                want_digit = !want_digit;
                if (ifc.out_last) begin
                    check_eq("expr_format", 32'(expr_ok && !want_digit), 32'd1);
                    want_digit = 1'b1;
                    expr_ok    = 1'b1;
                end
            end
            stall_p   = ifc.out_valid && !ifc.out_ready;
            hold_char = ifc.out_char;
            hold_last = ifc.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        ifc.out_ready = 1'b1;
        cyc();
        cyc();
        check_eq("rst_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_last", 32'(ifc.out_last), 32'd0);
        check_eq("rst_char", 32'(ifc.out_char), 32'h00);
        clr_n = 1'b1;

        // Seed 3, two terms, then a start held across the final transfer.
        seed = 8'h03; terms = 4'd2; start = 1'b1;
        push_stream(8'h03, 2);
        cyc();
        start = 1'b0;
        check_eq("t1_c0", 32'(ifc.out_char), 32'h33);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_l0", 32'(ifc.out_last), 32'd0);
        cyc();
        check_eq("t1_c1", 32'(ifc.out_char), 32'h2B);
        cyc();
        check_eq("t1_c2", 32'(ifc.out_char), 32'h32);
        check_eq("t1_l2", 32'(ifc.out_last), 32'd1);
        seed = 8'h07; terms = 4'd1; start = 1'b1;
        cyc();
        check_eq("end_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_last", 32'(ifc.out_last), 32'd0);
        check_eq("end_char_held", 32'(ifc.out_char), 32'h32);
        push_stream(8'h07, 1);
        cyc();
        start = 1'b0;
        check_eq("t2_valid", 32'(ifc.out_valid), 32'd1);
        check_eq("t2_char", 32'(ifc.out_char), 32'h37);
        check_eq("t2_last", 32'(ifc.out_last), 32'd1);
        wait_idle(50);

        // Zero seed substitutes 8'h01.
        seed = 8'h00; terms = 4'd1; start = 1'b1;
        push_stream(8'h00, 1);
        cyc();
        start = 1'b0;
        check_eq("t3_char", 32'(ifc.out_char), 32'h31);
        wait_idle(50);

        // Backpressure on the first digit.
        ifc.out_ready = 1'b0;
        seed = 8'h03; terms = 4'd2; start = 1'b1;
        push_stream(8'h03, 2);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_char", 32'(ifc.out_char), 32'h33);
            cyc();
        end
        check_eq("bp_char4", 32'(ifc.out_char), 32'h33);
        ifc.out_ready = 1'b1;
        cyc();
        check_eq("bp_op", 32'(ifc.out_char), 32'h2B);
        wait_idle(50);

        // terms = 0 is a no-op.
        seed = 8'h05; terms = 4'd0; start = 1'b1;
        cyc();
        check_eq("z_valid", 32'(ifc.out_valid), 32'd0);
        cyc();
        start = 1'b0;
        check_eq("z_busy", 32'(busy), 32'd0);

        // Start pulsed while busy must not disturb the stream.
        seed = 8'h5A; terms = 4'd4; start = 1'b1;
        push_stream(8'h5A, 4);
        cyc();
        start = 1'b0;
        cyc();
        seed = 8'h11; terms = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("bz_busy", 32'(busy), 32'd1);
        wait_idle(100);
        check_eq("bz_sb_empty", 32'(exp_q.size()), 32'd0);

        // Random 15-term run with random backpressure.
        begin
            int n;
            seed = 8'($urandom_range(1, 255)); terms = 4'd15; start = 1'b1;
            push_stream(seed, 15);
            cyc();
            start = 1'b0;
            n = 0;
            while (busy && n < 500) begin
                ifc.out_ready = 1'($urandom_range(0, 1));
                cyc();
                n++;
            end
            ifc.out_ready = 1'b1;
            wait_idle(50);
            check_eq("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // Asynchronous reset mid-stream, then a full replay from the same seed.
        seed = 8'h9C; terms = 4'd5; start = 1'b1;
        push_stream(8'h9C, 5);
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("ar_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_last", 32'(ifc.out_last), 32'd0);
        exp_q.delete();
        cyc();
        clr_n = 1'b1;
        seed = 8'h9C; terms = 4'd5; start = 1'b1;
        push_stream(8'h9C, 5);
        cyc();
        start = 1'b0;
        check_eq("ar_first", 32'(ifc.out_char), 32'h32);
        wait_idle(100);
        check_eq("ar_sb_empty", 32'(exp_q.size()), 32'd0);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
